// File: rtl/branch_pkg.sv
// Shared branch definitions used by the resolve unit and the branch predictor.
// Provides the conditional-branch opcodes, the default in-flight queue depth,
// the queue entry record and an opcode classification helper.
package branch_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        taken;
    logic [31:0] target;
  } br_entry_t;

  function automatic logic is_cond_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_fifo.sv
// In-flight branch queue: circular buffer of DEPTH entries with head/tail
// pointers and an occupancy count.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push       : enqueue push_data at tail (accepted if not full, or if a pop
//                frees the slot in the same cycle)
//   pop        : dequeue head (ignored while empty)
//   flush      : empty the queue; overrides push and pop
//   full/empty : occupancy flags from the registered count
//   head_data  : oldest entry, valid while !empty
module branch_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  br_entry_t push_data,
  output logic      full,
  output logic      empty,
  output br_entry_t head_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  br_entry_t     mem_q [DEPTH];

  logic do_pop;
  logic do_push;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[head_q];

  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the head slot; tail equals head then,
  // and the head entry is read out before the edge that overwrites it.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PW'(1);
      if (do_pop)  head_d = head_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks predicted conditional branches between fetch and EX, resolves them in
// order, feeds the outcome back to the predictor and raises a one-cycle flush
// with the corrected fetch PC on a misprediction.
//   fetch_*            : instruction + prediction from fetch (BEQ/BNE queued)
//   resolve_valid/taken: EX resolves the oldest queued branch
//   fetch_stall        : queue full
//   modify_*/true_taken: registered resolution to predictor, zero when idle
//   mispredict         : one-cycle pulse, redirect_pc holds corrected PC
//   resolve_error      : sticky, resolve seen with an empty queue
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instruction,
  input  logic        fetch_taken,
  input  logic [31:0] fetch_target,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic        fetch_stall,
  output logic [31:0] modify_pc,
  output logic [31:0] modify_instruction,
  output logic        true_taken,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic        resolve_error
);

  br_entry_t push_data;
  br_entry_t head;
  logic      full;
  logic      empty;
  logic      push;
  logic      resolving;
  logic      flush;

  logic [31:0] modify_pc_q, modify_pc_d;
  logic [31:0] modify_instruction_q, modify_instruction_d;
  logic        true_taken_q, true_taken_d;
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        resolve_error_q, resolve_error_d;

  assign push_data = '{pc: fetch_pc, instruction: fetch_instruction,
                       taken: fetch_taken, target: fetch_target};
  assign push      = fetch_valid && is_cond_branch(fetch_instruction[31:26]);
  assign resolving = resolve_valid && !empty;
  // The queue is flushed at the resolving edge itself, so the mispredict pulse
  // seen one cycle later already finds it empty.
  assign flush     = resolving && (resolve_taken != head.taken);

  branch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (resolve_valid),
    .flush     (flush),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .head_data (head)
  );

  always_comb begin
    modify_pc_d          = '0;
    modify_instruction_d = '0;
    true_taken_d         = 1'b0;
    mispredict_d         = flush;
    redirect_pc_d        = '0;
    resolve_error_d      = resolve_error_q || (resolve_valid && empty);
    if (resolving) begin
      modify_pc_d          = head.pc;
      modify_instruction_d = head.instruction;
      true_taken_d         = resolve_taken;
    end
    if (flush) begin
      redirect_pc_d = resolve_taken ? head.target : head.pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      modify_pc_q          <= '0;
      modify_instruction_q <= '0;
      true_taken_q         <= 1'b0;
      mispredict_q         <= 1'b0;
      redirect_pc_q        <= '0;
      resolve_error_q      <= 1'b0;
    end else begin
      modify_pc_q          <= modify_pc_d;
      modify_instruction_q <= modify_instruction_d;
      true_taken_q         <= true_taken_d;
      mispredict_q         <= mispredict_d;
      redirect_pc_q        <= redirect_pc_d;
      resolve_error_q      <= resolve_error_d;
    end
  end

  assign fetch_stall        = full;
  assign modify_pc          = modify_pc_q;
  assign modify_instruction = modify_instruction_q;
  assign true_taken         = true_taken_q;
  assign mispredict         = mispredict_q;
  assign redirect_pc        = redirect_pc_q;
  assign resolve_error      = resolve_error_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table for the corner cases,
// then randomized traffic checked against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_instruction = '0;
  logic        fetch_taken = 1'b0;
  logic [31:0] fetch_target = '0;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic        fetch_stall;
  logic [31:0] modify_pc;
  logic [31:0] modify_instruction;
  logic        true_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        resolve_error;

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .fetch_instruction  (fetch_instruction),
    .fetch_taken        (fetch_taken),
    .fetch_target       (fetch_target),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .fetch_stall        (fetch_stall),
    .modify_pc          (modify_pc),
    .modify_instruction (modify_instruction),
    .true_taken         (true_taken),
    .mispredict         (mispredict),
    .redirect_pc        (redirect_pc),
    .resolve_error      (resolve_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, fv;
    logic [31:0] instr, pc;
    bit          tk;
    logic [31:0] tgt;
    bit          rv, rt;
    bit          cs, st;
    logic [31:0] mpc, mins;
    bit          tt, mis;
    logic [31:0] red;
    bit          err;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr;
    bit          tk;
    logic [31:0] tgt;
  } ment_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ment_t       mq[$];
  bit          m_err = 1'b0;
  logic [31:0] m_mpc = '0, m_mins = '0, m_red = '0;
  bit          m_tt = 1'b0, m_mis = 1'b0;

  vec_t tbl[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beq(input logic [31:0] pc);
    return {6'b000100, 10'd0, pc[15:0]};
  endfunction

  function automatic logic [31:0] bne(input logic [31:0] pc);
    return {6'b000101, 10'd0, pc[15:0]};
  endfunction

  function automatic vec_t mk(input int r, input int fv, input logic [31:0] instr,
                              input logic [31:0] pc, input int tk, input logic [31:0] tgt,
                              input int rv, input int rt, input int cs, input int st,
                              input logic [31:0] mpc, input logic [31:0] mins, input int tt,
                              input int mis, input logic [31:0] red, input int err);
    vec_t v;
    v.rst = (r != 0);  v.fv = (fv != 0); v.instr = instr; v.pc = pc;
    v.tk = (tk != 0);  v.tgt = tgt;      v.rv = (rv != 0); v.rt = (rt != 0);
    v.cs = (cs != 0);  v.st = (st != 0); v.mpc = mpc;      v.mins = mins;
    v.tt = (tt != 0);  v.mis = (mis != 0); v.red = red;    v.err = (err != 0);
    return v;
  endfunction

  // Model: one clock edge with the inputs currently applied.
  task automatic model_edge();
    int    sz;
    bit    pop, mis, isbr;
    ment_t h, e;
    sz   = mq.size();
    isbr = (fetch_instruction[31:26] == 6'h04) || (fetch_instruction[31:26] == 6'h05);
    if (rst) begin
      mq.delete();
      m_err = 1'b0; m_mpc = '0; m_mins = '0; m_tt = 1'b0; m_mis = 1'b0; m_red = '0;
      return;
    end
    pop = resolve_valid && (sz > 0);
    if (resolve_valid && sz == 0) m_err = 1'b1;
    mis = 1'b0;
    m_mpc = '0; m_mins = '0; m_tt = 1'b0; m_red = '0;
    if (pop) begin
      h = mq[0];
      m_mpc = h.pc; m_mins = h.instr; m_tt = resolve_taken;
      mis = (resolve_taken != h.tk);
      if (mis) m_red = resolve_taken ? h.tgt : h.pc + 32'd4;
    end
    m_mis = mis;
    if (mis) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (fetch_valid && isbr && (sz < DEPTH || pop)) begin
        e.pc = fetch_pc; e.instr = fetch_instruction; e.tk = fetch_taken; e.tgt = fetch_target;
        mq.push_back(e);
      end
    end
  endtask

  task automatic run(input vec_t v, input bit use_tbl, input string tag);
    bit st_exp;
    rst = v.rst; fetch_valid = v.fv; fetch_instruction = v.instr; fetch_pc = v.pc;
    fetch_taken = v.tk; fetch_target = v.tgt; resolve_valid = v.rv; resolve_taken = v.rt;
    st_exp = use_tbl ? v.st : (mq.size() == DEPTH);
    #1;
    if (!use_tbl || v.cs) check1({tag, " fetch_stall"}, fetch_stall, st_exp);
    model_edge();
    @(posedge clk);
    #1;
    if (use_tbl) begin
      check32({tag, " modify_pc"}, modify_pc, v.mpc);
      check32({tag, " modify_instruction"}, modify_instruction, v.mins);
      check1({tag, " true_taken"}, true_taken, v.tt);
      check1({tag, " mispredict"}, mispredict, v.mis);
      check32({tag, " redirect_pc"}, redirect_pc, v.red);
      check1({tag, " resolve_error"}, resolve_error, v.err);
    end else begin
      check32({tag, " modify_pc"}, modify_pc, m_mpc);
      check32({tag, " modify_instruction"}, modify_instruction, m_mins);
      check1({tag, " true_taken"}, true_taken, m_tt);
      check1({tag, " mispredict"}, mispredict, m_mis);
      check32({tag, " redirect_pc"}, redirect_pc, m_red);
      check1({tag, " resolve_error"}, resolve_error, m_err);
    end
  endtask

  initial begin
    vec_t v;
    logic [5:0] op;

    // reset
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0,0,0));
    // beq 0x40 predicted taken, resolves taken
    tbl.push_back(mk(0,1,beq('h40),'h40,1,'h80,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,1, 1,0, 'h40,beq('h40),1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0, 0,0,0,0,0,0));
    // bne 0x100 predicted taken, resolves not taken; same-cycle beq discarded
    tbl.push_back(mk(0,1,bne('h100),'h100,1,'h200,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,beq('h300),'h300,0,0,1,0, 1,0, 'h100,bne('h100),0,1,'h104,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0, 0,0,0,0,0,0));
    // resolve on empty queue
    tbl.push_back(mk(0,0,0,0,0,0,1,0, 1,0, 0,0,0,0,0,1));
    // add / lw are not queued
    tbl.push_back(mk(0,1,'h00221820,'h500,1,'h700,0,0, 1,0, 0,0,0,0,0,1));
    tbl.push_back(mk(0,1,'h8C220004,'h504,1,'h700,0,0, 1,0, 0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,0, 1,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,0,0,0,0,0));
    // fill, drop fifth, drain in order
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,1,beq('h10+4*k),'h10+4*k,0,'h1000,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,beq('h20),'h20,0,'h1000,0,0, 1,1, 0,0,0,0,0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0,0,0,0,1,0, 1,(k==0)?1:0, 'h10+4*k,beq('h10+4*k),0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,0, 1,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,0,0,0,0,0));
    // full queue: enqueue + correct resolve in the same cycle
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,1,beq('h40+4*k),'h40+4*k,1,'h2000,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,beq('h50),'h50,1,'h3000,1,1, 1,1, 'h40,beq('h40),1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1, 0,0,0,0,0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0,0,0,0,1,1, 1,(k==0)?1:0, 'h44+4*k,beq('h44+4*k),1,0,0,0));
    // reset wins over a same-cycle mispredicting resolve
    tbl.push_back(mk(0,1,beq('h60),'h60,0,'h600,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,bne('h64),'h64,1,'h700,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,1, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,0, 1,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,0,0,0,0,0));
    // predicted not-taken, actually taken -> redirect to target; then reset clears pulse
    tbl.push_back(mk(0,1,beq('h60),'h60,0,'h600,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,bne('h64),'h64,1,'h700,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,1, 1,0, 'h60,beq('h60),1,1,'h600,0));
    tbl.push_back(mk(1,1,beq('h70),'h70,1,'h90,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0, 0,0,0,0,0,0));
    // pc+4 wraps at 32 bits
    tbl.push_back(mk(0,1,bne('hFFFFFFFC),'hFFFFFFFC,1,'h10,0,0, 1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,0, 1,0, 'hFFFFFFFC,bne('hFFFFFFFC),0,1,0,0));

    foreach (tbl[i]) run(tbl[i], 1'b1, $sformatf("row%0d", i));

    for (int n = 0; n < 3000; n++) begin
      v = mk(0,0,0,0,0,0,0,0, 1,0, 0,0,0,0,0,0);
      v.rst = ($urandom_range(0, 127) == 0);
      v.fv  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 4))
        0:       op = 6'h04;
        1:       op = 6'h05;
        2:       op = 6'h00;
        3:       op = 6'h23;
        default: op = 6'($urandom);
      endcase
      v.instr = {op, 26'($urandom)};
      v.pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      v.tk    = 1'($urandom);
      v.tgt   = $urandom & 32'hFFFF_FFFC;
      v.rv    = ($urandom_range(0, 99) < 45);
      v.rt    = 1'($urandom);
      run(v, 1'b0, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
